arbiter_wrr: RTL
================

ARBITER_WRR -- requirements
Module: arbiter_wrr

Interface
REQ-001 Parameter NUM_PORTS, default 6: number of requesting actors, legal range 2..32.
REQ-002 Parameter CNT_WIDTH, default 4: width of each per-port weight and of the credit counter.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 request  input  NUM_PORTS  bit i high = port i requests the shared resource.
REQ-006 weight  input  NUM_PORTS*CNT_WIDTH  port i quota in bits [i*CNT_WIDTH +: CNT_WIDTH]; consecutive grant cycles allowed per turn.
REQ-007 grant  output  NUM_PORTS  registered one-hot (or zero) grant; bit i = port i owns resource this cycle.
REQ-008 grant_id  output  clog2(NUM_PORTS)  registered binary index of granted port; 0 when no grant.
REQ-009 active  output  1  registered; high exactly when grant is non-zero.

Function
REQ-010 Internal state: owner index (one-hot token) and credit counter (CNT_WIDTH bits).
REQ-011 Eligible = request[owner] high and credit != 0, evaluated on current-cycle inputs.
REQ-012 If eligible: next grant = owner; credit decrements by 1; owner unchanged.
REQ-013 Else if any request bit high: scan ports owner+1, owner+2, ... wrapping through owner itself (owner lowest priority); first requester becomes new owner and is granted next cycle.
REQ-014 On owner change: credit loads weight[new]-1; weight 0 treated as 1 (credit loads 0).
REQ-015 Else (no requests): grant, grant_id, active go to 0; owner and credit hold.
REQ-016 Grant latency: request sampled at edge N appears on grant after edge N (one register stage); no combinational path request->grant.
REQ-017 Owner dropping request mid-quota: remaining credit forfeited; next edge grants next requester per REQ-013.
REQ-018 Only requester is owner with credit 0: owner re-selected (wrap scan), credit reloads, grant continuous with no idle cycle.
REQ-019 Weight changes take effect only at the next credit load; in-progress credit unaffected.
REQ-020 grant never has more than one bit set; grant[i] implies request[i] was high on the sampling edge.
REQ-021 Starvation bound: a continuously requesting port is granted within sum of all other ports' effective weights +1 cycles.

Reset
REQ-022 While rst high at an edge: owner = port 0, credit = 0, grant = 0, grant_id = 0, active = 0; request ignored.
REQ-023 Reset asserted mid-operation aborts current turn; first post-reset arbitration scans from port 1 with port 0 last.

Verification
REQ-024 Reset, then request=all ones, all weights 1 -> grant order ports 1,2,3,4,5,0,1,... one per cycle, active constant 1.
REQ-025 All request, weight[2]=3 others 1 -> port 2 granted 3 consecutive cycles per round, others 1 each; round length 8 cycles.
REQ-026 Only port 4 requesting, weight[4]=2 -> grant_id=4 every cycle without gaps; credit reload on wrap.
REQ-027 Port 1 owner with weight 5, drops request after 2 grants while port 3 requests -> next cycle grant_id=3.
REQ-028 rst asserted for 1 cycle mid-quota of port 3 -> outputs 0 the following cycle, then arbitration resumes from port 1.
REQ-029 Random request/weight stimulus, NUM_PORTS=3 and 32 -> assertions: grant one-hot/zero, active==|grant, grant_id matches grant, starvation bound REQ-021 holds.

Source files
------------

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: the owning port keeps the grant for up to its weight in
// consecutive cycles, then ownership rotates to the next requester after it.
module arbiter_wrr #(
  parameter int unsigned NUM_PORTS = 6,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           request,
  input  logic [NUM_PORTS*CNT_WIDTH-1:0] weight,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
  output logic                           active
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  logic [IdxW-1:0]      owner_q, owner_d;
  logic [CNT_WIDTH-1:0] credit_q, credit_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]      grant_id_q, grant_id_d;
  logic                 active_q, active_d;

  logic                 found;
  logic [IdxW-1:0]      cand;
  logic [CNT_WIDTH-1:0] w_new;
  int unsigned          pos;

  always_comb begin
    owner_d    = owner_q;
    credit_d   = credit_q;
    grant_d    = '0;
    grant_id_d = '0;
    active_d   = 1'b0;
    found      = 1'b0;
    cand       = '0;
    w_new      = '0;
    pos        = 0;

    if (request[owner_q] && (credit_q != '0)) begin
      credit_d          = credit_q - CNT_WIDTH'(1);
      grant_d[owner_q]  = 1'b1;
      grant_id_d        = owner_q;
      active_d          = 1'b1;
    end else if (|request) begin
      // Scan owner+1 .. owner+NUM_PORTS so the current owner is visited last.
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
        pos = 32'(owner_q) + i;
        if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
        if (!found && request[IdxW'(pos)]) begin
          found = 1'b1;
          cand  = IdxW'(pos);
        end
      end
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (32'(cand) == p) w_new = weight[p*CNT_WIDTH +: CNT_WIDTH];
      end
      owner_d        = cand;
      // The grant issued now spends one unit of quota; weight 0 behaves as 1.
      credit_d       = (w_new == '0) ? '0 : w_new - CNT_WIDTH'(1);
      grant_d[cand]  = 1'b1;
      grant_id_d     = cand;
      active_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= '0;
      credit_q   <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      active_q   <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      credit_q   <= credit_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      active_q   <= active_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign active   = active_q;

endmodule
